// File: rtl/pic_command_sequencer.sv
// ============================================================================
// Module   : pic_command_sequencer
// Purpose  : 8259A-style ICW/OCW command front end and status read-back path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pic_command_sequencer #(
    parameter int NUM_IRQ = 8
) (
    input  logic               clk,
    input  logic               reset_bar,
    input  logic               chip_select_bar,
    input  logic               read_bar,
    input  logic               write_bar,
    input  logic               A0,
    input  logic [7:0]         data_in,
    output logic [7:0]         data_out,
    output logic               data_out_en,
    input  logic [NUM_IRQ-1:0] irr_in,
    input  logic [NUM_IRQ-1:0] isr_in,
    input  logic [7:0]         poll_word_in,
    output logic               init_done,
    output logic               ltim,
    output logic               single,
    output logic               ic4,
    output logic [4:0]         vector_base,
    output logic [7:0]         cascade_cfg,
    output logic               upm,
    output logic               aeoi,
    output logic               ms,
    output logic               buf_mode,
    output logic               sfnm,
    output logic [NUM_IRQ-1:0] imr,
    output logic               ocw2_valid,
    output logic [2:0]         ocw2_cmd,
    output logic [2:0]         ocw2_level,
    output logic               special_mask,
    output logic               poll_req
);

    typedef enum logic [2:0] {
        ST_UNINIT    = 3'd0,
        ST_WAIT_ICW2 = 3'd1,
        ST_WAIT_ICW3 = 3'd2,
        ST_WAIT_ICW4 = 3'd3,
        ST_READY     = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic               wr_prev_q, wr_prev_d;
    logic               rd_prev_q, rd_prev_d;
    logic               ltim_q, ltim_d;
    logic               single_q, single_d;
    logic               ic4_q, ic4_d;
    logic [4:0]         vector_base_q, vector_base_d;
    logic [7:0]         cascade_cfg_q, cascade_cfg_d;
    logic               upm_q, upm_d;
    logic               aeoi_q, aeoi_d;
    logic               ms_q, ms_d;
    logic               buf_mode_q, buf_mode_d;
    logic               sfnm_q, sfnm_d;
    logic [NUM_IRQ-1:0] imr_q, imr_d;
    logic               ocw2_valid_q, ocw2_valid_d;
    logic [2:0]         ocw2_cmd_q, ocw2_cmd_d;
    logic [2:0]         ocw2_level_q, ocw2_level_d;
    logic               special_mask_q, special_mask_d;
    logic               poll_req_q, poll_req_d;
    logic               read_isr_q, read_isr_d;
    logic               poll_pend_q, poll_pend_d;
    logic               poll_rd_q, poll_rd_d;
    logic [7:0]         data_out_q, data_out_d;
    logic               data_out_en_q, data_out_en_d;

    logic               wr_act, rd_act, wr_acc, rd_acc;
    logic [7:0]         imr_ext, irr_ext, isr_ext;

    // A simultaneous read is suppressed so the write always wins.
    assign wr_act = ~chip_select_bar & ~write_bar;
    assign rd_act = ~chip_select_bar & ~read_bar & write_bar;
    assign wr_acc = wr_act & ~wr_prev_q;
    assign rd_acc = rd_act & ~rd_prev_q;

    always_comb begin
        imr_ext                = '0;
        irr_ext                = '0;
        isr_ext                = '0;
        imr_ext[NUM_IRQ-1:0]   = imr_q;
        irr_ext[NUM_IRQ-1:0]   = irr_in;
        isr_ext[NUM_IRQ-1:0]   = isr_in;

        state_d        = state_q;
        wr_prev_d      = wr_act;
        rd_prev_d      = rd_act;
        ltim_d         = ltim_q;
        single_d       = single_q;
        ic4_d          = ic4_q;
        vector_base_d  = vector_base_q;
        cascade_cfg_d  = cascade_cfg_q;
        upm_d          = upm_q;
        aeoi_d         = aeoi_q;
        ms_d           = ms_q;
        buf_mode_d     = buf_mode_q;
        sfnm_d         = sfnm_q;
        imr_d          = imr_q;
        ocw2_valid_d   = 1'b0;
        ocw2_cmd_d     = ocw2_cmd_q;
        ocw2_level_d   = ocw2_level_q;
        special_mask_d = special_mask_q;
        poll_req_d     = 1'b0;
        read_isr_d     = read_isr_q;
        poll_pend_d    = poll_pend_q;
        poll_rd_d      = poll_rd_q;
        data_out_d     = data_out_q;
        data_out_en_d  = rd_acc | (data_out_en_q & rd_act);

        // A served poll stays pending until its read strobe ends.
        if (data_out_en_q && !rd_act) begin
            poll_rd_d = 1'b0;
            if (poll_rd_q) begin
                poll_pend_d = 1'b0;
            end
        end

        if (rd_acc) begin
            if (poll_pend_q && !A0) begin
                data_out_d = poll_word_in;
                poll_rd_d  = 1'b1;
            end else if (A0) begin
                data_out_d = imr_ext;
            end else begin
                data_out_d = read_isr_q ? isr_ext : irr_ext;
            end
        end

        if (wr_acc) begin
            if (!A0 && data_in[4]) begin
                ltim_d         = data_in[3];
                single_d       = data_in[1];
                ic4_d          = data_in[0];
                imr_d          = '0;
                cascade_cfg_d  = 8'h00;
                upm_d          = 1'b0;
                aeoi_d         = 1'b0;
                ms_d           = 1'b0;
                buf_mode_d     = 1'b0;
                sfnm_d         = 1'b0;
                special_mask_d = 1'b0;
                read_isr_d     = 1'b0;
                poll_pend_d    = 1'b0;
                poll_rd_d      = 1'b0;
                state_d        = ST_WAIT_ICW2;
            end else begin
                case (state_q)
                    ST_WAIT_ICW2: begin
                        if (A0) begin
                            vector_base_d = data_in[7:3];
                            if (!single_q)   state_d = ST_WAIT_ICW3;
                            else if (ic4_q)  state_d = ST_WAIT_ICW4;
                            else             state_d = ST_READY;
                        end
                    end
                    ST_WAIT_ICW3: begin
                        if (A0) begin
                            cascade_cfg_d = data_in;
                            state_d       = ic4_q ? ST_WAIT_ICW4 : ST_READY;
                        end
                    end
                    ST_WAIT_ICW4: begin
                        if (A0) begin
                            upm_d      = data_in[0];
                            aeoi_d     = data_in[1];
                            ms_d       = data_in[2];
                            buf_mode_d = data_in[3];
                            sfnm_d     = data_in[4];
                            state_d    = ST_READY;
                        end
                    end
                    ST_READY: begin
                        if (A0) begin
                            imr_d = data_in[NUM_IRQ-1:0];
                        end else if (!data_in[3]) begin
                            ocw2_valid_d = 1'b1;
                            ocw2_cmd_d   = data_in[7:5];
                            ocw2_level_d = data_in[2:0];
                        end else begin
                            if (data_in[1]) read_isr_d     = data_in[0];
                            if (data_in[6]) special_mask_d = data_in[5];
                            if (data_in[2]) begin
                                poll_req_d  = 1'b1;
                                poll_pend_d = 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Edge-history flops reset high so a strobe held across reset is not accepted.
    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            state_q        <= ST_UNINIT;
            wr_prev_q      <= 1'b1;
            rd_prev_q      <= 1'b1;
            ltim_q         <= 1'b0;
            single_q       <= 1'b0;
            ic4_q          <= 1'b0;
            vector_base_q  <= 5'd0;
            cascade_cfg_q  <= 8'h00;
            upm_q          <= 1'b0;
            aeoi_q         <= 1'b0;
            ms_q           <= 1'b0;
            buf_mode_q     <= 1'b0;
            sfnm_q         <= 1'b0;
            imr_q          <= '0;
            ocw2_valid_q   <= 1'b0;
            ocw2_cmd_q     <= 3'd0;
            ocw2_level_q   <= 3'd0;
            special_mask_q <= 1'b0;
            poll_req_q     <= 1'b0;
            read_isr_q     <= 1'b0;
            poll_pend_q    <= 1'b0;
            poll_rd_q      <= 1'b0;
            data_out_q     <= 8'h00;
            data_out_en_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_prev_q      <= wr_prev_d;
            rd_prev_q      <= rd_prev_d;
            ltim_q         <= ltim_d;
            single_q       <= single_d;
            ic4_q          <= ic4_d;
            vector_base_q  <= vector_base_d;
            cascade_cfg_q  <= cascade_cfg_d;
            upm_q          <= upm_d;
            aeoi_q         <= aeoi_d;
            ms_q           <= ms_d;
            buf_mode_q     <= buf_mode_d;
            sfnm_q         <= sfnm_d;
            imr_q          <= imr_d;
            ocw2_valid_q   <= ocw2_valid_d;
            ocw2_cmd_q     <= ocw2_cmd_d;
            ocw2_level_q   <= ocw2_level_d;
            special_mask_q <= special_mask_d;
            poll_req_q     <= poll_req_d;
            read_isr_q     <= read_isr_d;
            poll_pend_q    <= poll_pend_d;
            poll_rd_q      <= poll_rd_d;
            data_out_q     <= data_out_d;
            data_out_en_q  <= data_out_en_d;
        end
    end

    assign data_out     = data_out_q;
    assign data_out_en  = data_out_en_q;
    assign init_done    = (state_q == ST_READY);
    assign ltim         = ltim_q;
    assign single       = single_q;
    assign ic4          = ic4_q;
    assign vector_base  = vector_base_q;
    assign cascade_cfg  = cascade_cfg_q;
    assign upm          = upm_q;
    assign aeoi         = aeoi_q;
    assign ms           = ms_q;
    assign buf_mode     = buf_mode_q;
    assign sfnm         = sfnm_q;
    assign imr          = imr_q;
    assign ocw2_valid   = ocw2_valid_q;
    assign ocw2_cmd     = ocw2_cmd_q;
    assign ocw2_level   = ocw2_level_q;
    assign special_mask = special_mask_q;
    assign poll_req     = poll_req_q;

endmodule

`default_nettype wire

// File: tb/tb_pic_command_sequencer.sv
// ============================================================================
// Module   : tb_pic_command_sequencer
// Purpose  : Directed vector table, corner sequences and random traffic
//            against a transaction-level model, on 8- and 4-line instances.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pic_command_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_bar, chip_select_bar, read_bar, write_bar, A0;
    logic [7:0] data_in, irr_in, isr_in, poll_word_in;

    logic [7:0] d8_data_out;  logic d8_data_out_en, d8_init_done, d8_ltim, d8_single, d8_ic4;
    logic [4:0] d8_vector_base; logic [7:0] d8_cascade_cfg;
    logic       d8_upm, d8_aeoi, d8_ms, d8_buf_mode, d8_sfnm;
    logic [7:0] d8_imr; logic d8_ocw2_valid; logic [2:0] d8_ocw2_cmd, d8_ocw2_level;
    logic       d8_special_mask, d8_poll_req;

    logic [7:0] d4_data_out;  logic d4_data_out_en, d4_init_done, d4_ltim, d4_single, d4_ic4;
    logic [4:0] d4_vector_base; logic [7:0] d4_cascade_cfg;
    logic       d4_upm, d4_aeoi, d4_ms, d4_buf_mode, d4_sfnm;
    logic [3:0] d4_imr; logic d4_ocw2_valid; logic [2:0] d4_ocw2_cmd, d4_ocw2_level;
    logic       d4_special_mask, d4_poll_req;

    pic_command_sequencer #(.NUM_IRQ(8)) dut8 (
        .clk(clk), .reset_bar(reset_bar), .chip_select_bar(chip_select_bar),
        .read_bar(read_bar), .write_bar(write_bar), .A0(A0), .data_in(data_in),
        .data_out(d8_data_out), .data_out_en(d8_data_out_en),
        .irr_in(irr_in), .isr_in(isr_in), .poll_word_in(poll_word_in),
        .init_done(d8_init_done), .ltim(d8_ltim), .single(d8_single), .ic4(d8_ic4),
        .vector_base(d8_vector_base), .cascade_cfg(d8_cascade_cfg),
        .upm(d8_upm), .aeoi(d8_aeoi), .ms(d8_ms), .buf_mode(d8_buf_mode), .sfnm(d8_sfnm),
        .imr(d8_imr), .ocw2_valid(d8_ocw2_valid), .ocw2_cmd(d8_ocw2_cmd),
        .ocw2_level(d8_ocw2_level), .special_mask(d8_special_mask), .poll_req(d8_poll_req)
    );

    pic_command_sequencer #(.NUM_IRQ(4)) dut4 (
        .clk(clk), .reset_bar(reset_bar), .chip_select_bar(chip_select_bar),
        .read_bar(read_bar), .write_bar(write_bar), .A0(A0), .data_in(data_in),
        .data_out(d4_data_out), .data_out_en(d4_data_out_en),
        .irr_in(irr_in[3:0]), .isr_in(isr_in[3:0]), .poll_word_in(poll_word_in),
        .init_done(d4_init_done), .ltim(d4_ltim), .single(d4_single), .ic4(d4_ic4),
        .vector_base(d4_vector_base), .cascade_cfg(d4_cascade_cfg),
        .upm(d4_upm), .aeoi(d4_aeoi), .ms(d4_ms), .buf_mode(d4_buf_mode), .sfnm(d4_sfnm),
        .imr(d4_imr), .ocw2_valid(d4_ocw2_valid), .ocw2_cmd(d4_ocw2_cmd),
        .ocw2_level(d4_ocw2_level), .special_mask(d4_special_mask), .poll_req(d4_poll_req)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    bit         m_started;
    int         m_todo[$];      // ICW numbers still owed before READY
    bit         m_ltim, m_single, m_ic4, m_upm, m_aeoi, m_ms, m_buf, m_sfnm;
    logic [4:0] m_vb;
    logic [7:0] m_casc, m_imr;
    bit         m_smm, m_rsel, m_pend, m_ocw2p, m_pollp;
    logic [2:0] m_cmd, m_lvl;

    function automatic bit m_ready();
        return m_started && (m_todo.size() == 0);
    endfunction

    task automatic model_reset();
        m_started = 0; m_todo = {};
        {m_ltim, m_single, m_ic4, m_upm, m_aeoi, m_ms, m_buf, m_sfnm} = '0;
        m_vb = 0; m_casc = 0; m_imr = 0;
        m_smm = 0; m_rsel = 0; m_pend = 0; m_ocw2p = 0; m_pollp = 0;
        m_cmd = 0; m_lvl = 0;
    endtask

    task automatic model_write(input bit a0, input logic [7:0] d);
        m_ocw2p = 0; m_pollp = 0;
        if (!a0 && d[4]) begin
            m_ltim = d[3]; m_single = d[1]; m_ic4 = d[0];
            m_imr = 0; m_casc = 0; {m_upm, m_aeoi, m_ms, m_buf, m_sfnm} = '0;
            m_smm = 0; m_rsel = 0; m_pend = 0;
            m_started = 1;
            m_todo = {2};
            if (!d[1]) m_todo.push_back(3);
            if (d[0])  m_todo.push_back(4);
        end else if (m_started && m_todo.size() > 0) begin
            if (a0) begin
                case (m_todo[0])
                    2:       m_vb = d[7:3];
                    3:       m_casc = d;
                    default: {m_sfnm, m_buf, m_ms, m_aeoi, m_upm} = d[4:0];
                endcase
                void'(m_todo.pop_front());
            end
        end else if (m_ready()) begin
            if (a0) m_imr = d;
            else if (!d[3]) begin
                m_ocw2p = 1; m_cmd = d[7:5]; m_lvl = d[2:0];
            end else begin
                if (d[1]) m_rsel = d[0];
                if (d[6]) m_smm = d[5];
                if (d[2]) begin m_pollp = 1; m_pend = 1; end
            end
        end
    endtask

    task automatic model_read(input bit a0, input logic [7:0] irr, input logic [7:0] isr,
                              input logic [7:0] poll, output logic [7:0] e8, output logic [7:0] e4);
        if (m_pend && !a0) begin
            e8 = poll; e4 = poll; m_pend = 0;
        end else if (a0) begin
            e8 = m_imr; e4 = {4'h0, m_imr[3:0]};
        end else begin
            e8 = m_rsel ? isr : irr;
            e4 = {4'h0, e8[3:0]};
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_state8"},
            {d8_init_done, d8_ltim, d8_single, d8_ic4, d8_vector_base, d8_cascade_cfg,
             d8_upm, d8_aeoi, d8_ms, d8_buf_mode, d8_sfnm, d8_imr, d8_special_mask,
             d8_ocw2_cmd, d8_ocw2_level, d8_ocw2_valid, d8_poll_req, d8_data_out_en},
            {m_ready(), m_ltim, m_single, m_ic4, m_vb, m_casc,
             m_upm, m_aeoi, m_ms, m_buf, m_sfnm, m_imr, m_smm,
             m_cmd, m_lvl, m_ocw2p, m_pollp, 1'b0});
        chk({tag, "_state4"},
            {d4_init_done, d4_vector_base, d4_imr, d4_special_mask, d4_ocw2_cmd,
             d4_ocw2_level, d4_ocw2_valid, d4_poll_req, d4_data_out_en},
            {m_ready(), m_vb, m_imr[3:0], m_smm, m_cmd, m_lvl, m_ocw2p, m_pollp, 1'b0});
    endtask

    // ---------------- bus tasks (entered and left on a falling clock edge) ----------------
    task automatic do_write(input bit a0, input logic [7:0] d, input int len,
                            output logic [1:0] seen);
        chip_select_bar = 0; write_bar = 0; A0 = a0; data_in = d;
        model_write(a0, d);
        @(negedge clk);
        seen = {d8_ocw2_valid, d8_poll_req};
        chk("wr_pulse8", {d8_ocw2_valid, d8_poll_req}, {m_ocw2p, m_pollp});
        chk("wr_pulse4", {d4_ocw2_valid, d4_poll_req}, {m_ocw2p, m_pollp});
        for (int i = 1; i < len; i++) begin
            data_in = 8'($urandom);
            @(negedge clk);
        end
        chip_select_bar = 1; write_bar = 1; data_in = 8'($urandom);
        m_ocw2p = 0; m_pollp = 0;
        @(negedge clk);
        check_state("wr");
    endtask

    task automatic do_read(input bit a0, input logic [7:0] irr, input logic [7:0] isr,
                           input logic [7:0] poll, input int len, output logic [7:0] seen);
        logic [7:0] e8, e4;
        chip_select_bar = 0; read_bar = 0; A0 = a0;
        irr_in = irr; isr_in = isr; poll_word_in = poll;
        model_read(a0, irr, isr, poll, e8, e4);
        @(negedge clk);
        seen = d8_data_out;
        chk("rd_data8", {d8_data_out_en, d8_data_out}, {1'b1, e8});
        chk("rd_data4", {d4_data_out_en, d4_data_out}, {1'b1, e4});
        for (int i = 1; i < len; i++) begin
            irr_in = 8'($urandom); isr_in = 8'($urandom); poll_word_in = 8'($urandom);
            @(negedge clk);
        end
        if (len > 1) chk("rd_hold8", {d8_data_out_en, d8_data_out}, {1'b1, e8});
        chip_select_bar = 1; read_bar = 1;
        @(negedge clk);
        check_state("rd");
    endtask

    typedef struct {
        bit         rd;
        bit         a0;
        logic [7:0] d, irr, isr, poll;
        logic [1:0] ep;       // {ocw2_valid, poll_req} after a write
        bit         ei;       // init_done
        logic [7:0] eimr;
        logic [4:0] evb;
        logic [7:0] eout;     // read data (8-line instance)
    } vec_t;

    function automatic vec_t wv(bit a0, logic [7:0] d, logic [1:0] ep, bit ei,
                                logic [7:0] eimr, logic [4:0] evb);
        vec_t v;
        v = '{rd: 0, a0: a0, d: d, irr: 0, isr: 0, poll: 0, ep: ep, ei: ei,
              eimr: eimr, evb: evb, eout: 0};
        return v;
    endfunction

    function automatic vec_t rv(bit a0, logic [7:0] irr, logic [7:0] isr,
                                logic [7:0] poll, logic [7:0] eout);
        vec_t v;
        v = '{rd: 1, a0: a0, d: 0, irr: irr, isr: isr, poll: poll, ep: 0, ei: 0,
              eimr: 0, evb: 0, eout: eout};
        return v;
    endfunction

    vec_t tbl[24];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] sp;
        logic [7:0] sd;

        tbl[0]  = wv(0, 8'h11, 2'b00, 0, 8'h00, 5'h00);
        tbl[1]  = wv(1, 8'h40, 2'b00, 0, 8'h00, 5'h08);
        tbl[2]  = wv(1, 8'h04, 2'b00, 0, 8'h00, 5'h08);
        tbl[3]  = wv(1, 8'h01, 2'b00, 1, 8'h00, 5'h08);
        tbl[4]  = wv(0, 8'h63, 2'b10, 1, 8'h00, 5'h08);
        tbl[5]  = wv(0, 8'h0B, 2'b00, 1, 8'h00, 5'h08);
        tbl[6]  = rv(0, 8'h12, 8'h81, 8'h00, 8'h81);
        tbl[7]  = wv(0, 8'h0A, 2'b00, 1, 8'h00, 5'h08);
        tbl[8]  = wv(0, 8'h0C, 2'b01, 1, 8'h00, 5'h08);
        tbl[9]  = rv(0, 8'h33, 8'h44, 8'h85, 8'h85);
        tbl[10] = rv(0, 8'h33, 8'h44, 8'h85, 8'h33);
        tbl[11] = wv(1, 8'hFF, 2'b00, 1, 8'hFF, 5'h08);
        tbl[12] = rv(1, 8'h00, 8'h00, 8'h00, 8'hFF);
        tbl[13] = wv(0, 8'h12, 2'b00, 0, 8'h00, 5'h08);
        tbl[14] = wv(1, 8'h20, 2'b00, 1, 8'h00, 5'h04);
        tbl[15] = wv(1, 8'hF0, 2'b00, 1, 8'hF0, 5'h04);
        tbl[16] = wv(0, 8'h13, 2'b00, 0, 8'h00, 5'h04);
        tbl[17] = wv(0, 8'h20, 2'b00, 0, 8'h00, 5'h04);
        tbl[18] = wv(1, 8'h48, 2'b00, 0, 8'h00, 5'h09);
        tbl[19] = wv(0, 8'h11, 2'b00, 0, 8'h00, 5'h09);
        tbl[20] = wv(1, 8'h50, 2'b00, 0, 8'h00, 5'h0A);
        tbl[21] = wv(1, 8'h02, 2'b00, 0, 8'h00, 5'h0A);
        tbl[22] = wv(1, 8'h1F, 2'b00, 1, 8'h00, 5'h0A);
        tbl[23] = rv(1, 8'h00, 8'h00, 8'h00, 8'h00);

        reset_bar = 0; chip_select_bar = 1; read_bar = 1; write_bar = 1; A0 = 0;
        data_in = 0; irr_in = 0; isr_in = 0; poll_word_in = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_state("reset");
        chk("reset_dout", {d8_data_out, d4_data_out}, 16'h0000);
        reset_bar = 1;
        @(negedge clk);

        // ---- directed table ----
        for (int i = 0; i < 24; i++) begin
            if (tbl[i].rd) begin
                do_read(tbl[i].a0, tbl[i].irr, tbl[i].isr, tbl[i].poll,
                        $urandom_range(1, 3), sd);
                chk($sformatf("tbl%0d_rdata", i), sd, tbl[i].eout);
            end else begin
                do_write(tbl[i].a0, tbl[i].d, $urandom_range(1, 3), sp);
                chk($sformatf("tbl%0d_pulse", i), sp, tbl[i].ep);
                chk($sformatf("tbl%0d_regs", i),
                    {d8_init_done, d8_imr, d8_vector_base},
                    {tbl[i].ei, tbl[i].eimr, tbl[i].evb});
            end
        end
        chk("icw4_fields", {d8_sfnm, d8_buf_mode, d8_ms, d8_aeoi, d8_upm, d8_cascade_cfg},
            {5'b11111, 8'h02});

        // ---- read and write strobes overlapping: write wins ----
        chip_select_bar = 0; read_bar = 0; write_bar = 0; A0 = 1; data_in = 8'h3C;
        model_write(1, 8'h3C);
        @(negedge clk);
        chk("overlap_en_a", {d8_data_out_en, d4_data_out_en}, 2'b00);
        @(negedge clk);
        chk("overlap_en_b", {d8_data_out_en, d4_data_out_en}, 2'b00);
        chip_select_bar = 1; read_bar = 1; write_bar = 1;
        @(negedge clk);
        check_state("overlap");
        chk("overlap_imr", d8_imr, 8'h3C);

        // ---- back-to-back writes with a single idle cycle ----
        do_write(1, 8'h11, 1, sp);
        do_write(1, 8'h22, 1, sp);
        chk("b2b_imr", {d8_imr, d4_imr}, {8'h22, 4'h2});

        // ---- asynchronous reset in WAIT_ICW3, strobe held across release ----
        do_write(0, 8'h19, 1, sp);
        do_write(1, 8'h40, 1, sp);
        do_read(0, 8'hA5, 8'h00, 8'h00, 1, sd);
        chk("pre_rst_dout", sd, 8'hA5);
        @(posedge clk);
        #2;
        chip_select_bar = 0; write_bar = 0; A0 = 0; data_in = 8'h19;
        reset_bar = 0;
        #1;
        model_reset();
        check_state("async_rst");
        chk("async_rst_dout", {d8_data_out, d4_data_out}, 16'h0000);
        @(negedge clk);
        reset_bar = 1;
        repeat (2) @(negedge clk);
        check_state("held_strobe");
        chip_select_bar = 1; write_bar = 1;
        @(negedge clk);
        do_write(0, 8'h19, 1, sp);
        chk("rst_restart_ltim", {d8_ltim, d8_ic4, d8_init_done}, 3'b110);

        // ---- randomized traffic against the model ----
        for (int n = 0; n < 400; n++) begin
            int          kind;
            bit          a0;
            logic [7:0]  d;
            kind = $urandom_range(0, 9);
            a0   = 1'($urandom);
            d    = 8'($urandom);
            if (kind == 0) begin
                d[4] = 1'b1;
                do_write(0, d, $urandom_range(1, 3), sp);
            end else if (kind <= 5) begin
                if (!a0) d[4] = 1'b0;
                do_write(a0, d, $urandom_range(1, 3), sp);
            end else begin
                do_read(a0, 8'($urandom), 8'($urandom), 8'($urandom),
                        $urandom_range(1, 3), sd);
            end
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
